// File: rtl/ber_pkg.sv
// Shared definitions for the BER checker: FSM encodings, default PRBS taps and
// the 64-bit parallel PRBS step also used by the transmit-side generator.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } ber_st_e;

  localparam int PRBS_N_DEF = 7;
  localparam int PRBS_M_DEF = 6;

  // state[0] is the most recent bit; result bit 63 is the first new bit.
  function automatic logic [63:0] prbs_next64(input logic [30:0] state,
                                              input int unsigned n,
                                              input int unsigned m);
    logic [30:0] s;
    logic        b;
    s           = state;
    prbs_next64 = '0;
    for (int j = 0; j < 64; j++) begin
      b                   = s[5'(n - 1)] ^ s[5'(m - 1)];
      prbs_next64[63 - j] = b;
      s                   = {s[29:0], b};
    end
  endfunction

endpackage

// File: rtl/ber_checker_if.sv
// Word stream in, lock/counter status out. Build with BER_CHK_INJECT_EN to
// add the INJ error-injection strobe.
interface ber_checker_if #(parameter int CNT_W = 32);
  logic             CLR;
  logic             DIN_VLD;
  logic [63:0]      DIN;
`ifdef BER_CHK_INJECT_EN
  logic             INJ;
`endif
  logic             LOCKED;
  logic             ERR_WORD;
  logic [CNT_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] WORD_CNT;

`ifdef BER_CHK_INJECT_EN
  modport master (output CLR, DIN_VLD, DIN, INJ, input LOCKED, ERR_WORD, ERR_CNT, WORD_CNT);
  modport slave  (input CLR, DIN_VLD, DIN, INJ, output LOCKED, ERR_WORD, ERR_CNT, WORD_CNT);
`else
  modport master (output CLR, DIN_VLD, DIN, input LOCKED, ERR_WORD, ERR_CNT, WORD_CNT);
  modport slave  (input CLR, DIN_VLD, DIN, output LOCKED, ERR_WORD, ERR_CNT, WORD_CNT);
`endif
endinterface

// File: rtl/ber_popcount64.sv
// Registered 64-bit population count, one cycle of latency.
module ber_popcount64 (
  input  logic        CLKS,
  input  logic        RSTXS,
  input  logic        en,
  input  logic [63:0] din,
  output logic [6:0]  pc
);
  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS)  pc <= '0;
    else if (en) pc <= 7'($countones(din));
  end
endmodule

// File: rtl/ber_checker.sv
// Self-aligning PRBS bit-error-rate checker for 64-bit deserialized words.
// Optional build macro: BER_CHK_INJECT_EN (adds INJ, flips EXP[0] per word).
module ber_checker import ber_pkg::*; #(
  parameter int PRBS_N     = PRBS_N_DEF,
  parameter int PRBS_M     = PRBS_M_DEF,
  parameter int CNT_W      = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 8
) (
  input  logic          CLKS,
  input  logic          RSTXS,
  ber_checker_if.slave  bus
);
  localparam int STAGES = 1;
  localparam int GW     = $clog2(LOCK_CNT + 1);

  ber_st_e          st, st_nxt;
  logic [GW-1:0]    good, good_nxt;
  logic [STAGES:0]  vld_pipe;
  logic [PRBS_N-1:0] gen_s;
  logic [63:0]      exp_w, exp_chk, mis;
  logic [1:0]       seed_nz;
  logic [6:0]       pc;
  logic             cnt_upd;
  logic             locked_q, err_word_q;
  logic [CNT_W-1:0] err_cnt, word_cnt;
  logic [CNT_W:0]   err_sum;

  assign exp_w = prbs_next64(31'(gen_s), PRBS_N, PRBS_M);
`ifdef BER_CHK_INJECT_EN
  assign exp_chk = exp_w ^ {63'd0, bus.INJ};
`else
  assign exp_chk = exp_w;
`endif

  // c0: mismatch capture and generator update (reseed only while searching,
  // so a bit error in VERIFY/LOCKED does not propagate into later words).
  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      vld_pipe <= '0;
      gen_s    <= '0;
      mis      <= '0;
      seed_nz  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.DIN_VLD};
      seed_nz  <= {seed_nz[0], seed_nz[0]};
      if (bus.DIN_VLD) begin
        mis        <= bus.DIN ^ exp_chk;
        seed_nz[0] <= |gen_s;
        gen_s      <= (st == ST_SEARCH) ? bus.DIN[PRBS_N-1:0] : exp_w[PRBS_N-1:0];
      end
    end
  end

  ber_popcount64 u_pc (.CLKS(CLKS), .RSTXS(RSTXS), .en(vld_pipe[0]), .din(mis), .pc(pc));

  always_comb begin
    st_nxt   = st;
    good_nxt = good;
    cnt_upd  = 1'b0;
    if (vld_pipe[STAGES]) begin
      unique case (st)
        ST_SEARCH: if (pc == 7'd0 && seed_nz[1]) begin
          st_nxt   = ST_VERIFY;
          good_nxt = '0;
        end
        ST_VERIFY: begin
          if (pc != 7'd0)                     st_nxt   = ST_SEARCH;
          else if (good == GW'(LOCK_CNT - 1)) st_nxt   = ST_LOCKED;
          else                                good_nxt = good + 1'b1;
        end
        ST_LOCKED: begin
          if (pc >= 7'(UNLOCK_ERR)) st_nxt  = ST_SEARCH;
          else                      cnt_upd = 1'b1;
        end
        default: st_nxt = ST_SEARCH;
      endcase
    end
  end

  assign err_sum = {1'b0, err_cnt} + (CNT_W + 1)'(pc);

  always_ff @(posedge CLKS or negedge RSTXS) begin
    if (!RSTXS) begin
      st         <= ST_SEARCH;
      good       <= '0;
      locked_q   <= 1'b0;
      err_word_q <= 1'b0;
      err_cnt    <= '0;
      word_cnt   <= '0;
    end else begin
      st       <= st_nxt;
      good     <= good_nxt;
      locked_q <= (st_nxt == ST_LOCKED);
      if (bus.CLR) begin
        err_word_q <= 1'b0;
        err_cnt    <= '0;
        word_cnt   <= '0;
      end else begin
        err_word_q <= cnt_upd && (pc != 7'd0);
        if (cnt_upd) begin
          err_cnt  <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          word_cnt <= (&word_cnt) ? word_cnt : word_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.LOCKED   = locked_q;
  assign bus.ERR_WORD = err_word_q;
  assign bus.ERR_CNT  = err_cnt;
  assign bus.WORD_CNT = word_cnt;

endmodule
